apb_uart_tx_slave: RTL
======================

Name: apb_uart_tx_slave

Overview:
APB slave peripheral that sits on the APB bridge's slave port, parallel to the GPIO slave, and serialises bytes onto a UART TX line. It uses the same 4-bit address, 8-bit data APB signalling as the GPIO slave. Written bytes are buffered in a small TX FIFO. A baud-rate counter and a frame state machine emit 8N1 frames, LSB first. Status and control are exposed through four byte-wide registers.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, range 2..8.
BAUD_RESET, 8'd15, reset value of BAUDDIV; bit period = BAUDDIV+1 PCLK cycles.

Ports:
PCLK  input  1  system clock; all state updates on the rising edge.
PRESETn  input  1  asynchronous active-low reset.
PSEL  input  1  slave select from the APB bridge.
PENABLE  input  1  APB access-phase strobe.
PWRITE  input  1  1 = write, 0 = read.
PADDR  input  4  register address.
PWDATA  input  8  write data.
PRDATA  output  8  read data.
PREADY  output  1  transfer complete.
tx_o  output  1  UART serial output; idles high.
irq_o  output  1  TX-FIFO-empty interrupt, level-sensitive.

Behaviour:
- Reset (async, PRESETn=0):
  - FIFO emptied; overflow flag=0; CTRL=0; BAUDDIV=BAUD_RESET; FSM=IDLE.
  - tx_o=1 immediately; PRDATA=0; PREADY=0; irq_o=0.
  - Reset mid-frame aborts the frame; tx_o goes high without waiting for a clock edge.
- APB handshake:
  - Zero wait states: PREADY=1 whenever PSEL&PENABLE, otherwise 0.
  - Writes commit on the PCLK edge where PSEL&PENABLE&PWRITE.
  - PRDATA is combinational from PADDR while PSEL&!PWRITE; otherwise 0.
- Register map:
  - 0x0 TXDATA: W pushes PWDATA into the FIFO. R returns 0.
  - 0x1 STATUS: R = {count[3:0], ovf, busy, empty, full}. W1C on bit3 (ovf); all other bits read-only.
  - 0x2 CTRL: bit0 TX_EN, bit1 IRQ_EN. Bits[7:2] read 0.
  - 0x3 BAUDDIV: R/W, 8 bits.
  - 0x4-0xF: reads return 0; writes are ignored.
- FIFO:
  - count ranges 0..FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0).
  - Push while full and no pop in the same cycle: byte dropped, ovf set (sticky), count unchanged.
  - Push and pop in the same cycle (including when full): both occur, count unchanged, no ovf.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Frame FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx_o=1. At an edge with TX_EN=1 and !empty: pop the head byte into the shift register, latch BAUDDIV into the bit timer, go to START; tx_o=0 from that edge.
  - START: tx_o=0 for BAUDDIV+1 cycles, then go to DATA.
  - DATA: shift out 8 bits LSB first, each held BAUDDIV+1 cycles; a 3-bit index counts them. After bit 7 go to STOP.
  - STOP: tx_o=1 for BAUDDIV+1 cycles. At the end, go to START directly if TX_EN&!empty (back-to-back frames, no idle gap); else go to IDLE.
  - Frame length is exactly 10*(BAUDDIV+1) cycles.
  - busy=1 in any state other than IDLE.
- Mid-operation changes:
  - BAUDDIV written mid-frame takes effect at the next frame start only.
  - TX_EN cleared mid-frame: the current frame completes; no further pops.
- BAUDDIV=0 gives one cycle per bit (legal).
- irq_o = IRQ_EN & TX_EN & empty & !busy, registered (one-cycle latency).

Test Plan:
- Reset: assert PRESETn=0 mid-frame -> tx_o=1 immediately; after release STATUS reads 8'h02 and BAUDDIV reads 8'h0F.
- Single frame: BAUDDIV=3, CTRL=1, write 0xA5 to TXDATA -> tx_o shows 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles; total 40 cycles; busy=1 throughout.
- Overflow: CTRL=0, write 9 bytes -> STATUS=8'h89 (count=8, ovf, full). Write 8'h08 to STATUS -> STATUS=8'h81. Set CTRL=1 -> 8 frames, in original order.
- Back-to-back frames: BAUDDIV=0, queue 0x00 then 0xFF -> 20 contiguous cycles with no idle cycle between the frames; then irq_o=1 when IRQ_EN=1.
- Simultaneous push and pop: FIFO full, write TXDATA on the exact pop edge -> count stays 8, ovf stays 0, and the new byte is transmitted last.
- Unmapped and mid-frame changes: read 0x7 -> PRDATA=0, PREADY=1. Write BAUDDIV=1 mid-frame -> current frame keeps its old bit period; next frame uses 2 cycles per bit.

Source files
------------

// File: rtl/apb_uart_tx_slave_if.sv
// rtl/apb_uart_tx_slave_if.sv - APB signal bundle (4-bit address, 8-bit data) for the UART TX slave
interface apb_uart_tx_slave_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_uart_tx_slave.sv
// rtl/apb_uart_tx_slave.sv - APB slave with TX FIFO and 8N1 UART serialiser
module apb_uart_tx_slave #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] BAUD_RESET = 8'd15
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_uart_tx_slave_if.slave    apb,
    output logic                  tx_o,
    output logic                  irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]    count_q;
    logic          ovf_q, tx_en_q, irq_en_q, irq_q;
    logic [7:0]    bauddiv_q;

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    baud_lat_q, baud_lat_d;

    logic access, wr_en, push, pop, launch;
    logic full, empty, busy, bit_end, start_ok;

    assign access   = apb.PSEL & apb.PENABLE;
    assign wr_en    = access & apb.PWRITE;
    assign push     = wr_en && (apb.PADDR == 4'h0);
    assign full     = (count_q == 4'(FIFO_DEPTH));
    assign empty    = (count_q == 4'd0);
    assign busy     = (state_q != S_IDLE);
    assign bit_end  = (timer_q == 8'd0);
    assign start_ok = tx_en_q & ~empty;

    assign apb.PREADY = access;
    assign irq_o      = irq_q;

    always_comb begin
        apb.PRDATA = 8'h00;
        if (apb.PSEL && !apb.PWRITE) begin
            case (apb.PADDR)
                4'h1:    apb.PRDATA = {count_q, ovf_q, busy, empty, full};
                4'h2:    apb.PRDATA = {6'b0, irq_en_q, tx_en_q};
                4'h3:    apb.PRDATA = bauddiv_q;
                default: apb.PRDATA = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        baud_lat_d = baud_lat_q;
        launch     = 1'b0;
        if (!bit_end) timer_d = timer_q - 8'd1;
        case (state_q)
            S_IDLE: launch = start_ok;
            S_START: if (bit_end) begin
                state_d = S_DATA;
                timer_d = baud_lat_q;
                idx_d   = 3'd0;
            end
            S_DATA: if (bit_end) begin
                timer_d = baud_lat_q;
                if (idx_q == 3'd7) begin
                    state_d = S_STOP;
                end else begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: if (bit_end) begin
                if (start_ok) launch  = 1'b1;
                else          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new frame always samples the live BAUDDIV; the frame in flight keeps its latched copy.
        if (launch) begin
            shift_d    = mem_q[rd_ptr_q];
            baud_lat_d = bauddiv_q;
            timer_d    = bauddiv_q;
            state_d    = S_START;
        end
    end

    assign pop = launch;

    always_comb begin
        case (state_q)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = shift_q[0];
            default: tx_o = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= S_IDLE;
            timer_q    <= 8'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            baud_lat_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            baud_lat_q <= baud_lat_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push && (!full || pop)) mem_q[wr_ptr_q] <= apb.PWDATA;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 4'd0;
            ovf_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            bauddiv_q <= BAUD_RESET;
            irq_q     <= 1'b0;
        end else begin
            if (wr_en && (apb.PADDR == 4'h1) && apb.PWDATA[3]) ovf_q <= 1'b0;
            if (wr_en && (apb.PADDR == 4'h2)) begin
                tx_en_q  <= apb.PWDATA[0];
                irq_en_q <= apb.PWDATA[1];
            end
            if (wr_en && (apb.PADDR == 4'h3)) bauddiv_q <= apb.PWDATA;
            case ({push, pop})
                2'b10: begin
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        count_q  <= count_q + 4'd1;
                    end
                end
                2'b01: begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                    count_q  <= count_q - 4'd1;
                end
                2'b11: begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                default: ;
            endcase
            irq_q <= irq_en_q & tx_en_q & empty & ~busy;
        end
    end
endmodule
